// File: rtl/pusch_dr_pkg.sv
// Shared types and sizing for the PUSCH beam-selection datapath.
// The sorter slot struct is used by both the top and each slot cell.
package pusch_dr_pkg;

    localparam int NBEAMS = 64;
    localparam int BEAM   = 16;
    localparam int PWR_W  = 32;
    localparam int IDX_W  = 8;
    // Counter must also hold the saturated value NBEAMS itself.
    localparam int CNT_W  = $clog2(NBEAMS + 1);

    typedef struct packed {
        logic             vld;
        logic [PWR_W-1:0] pwr;
        logic [IDX_W-1:0] idx;
    } sort_slot_t;

endpackage

// File: rtl/beam_sort_cell.sv
// One slot of the insertion-sort chain: holds {vld, pwr, idx} and reports whether
// the incoming sample outranks it.
module beam_sort_cell
    import pusch_dr_pkg::*;
#(
    parameter bit IS_TOP = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  sort_slot_t upper_slot,
    input  sort_slot_t new_slot,
    input  logic       upper_gt,
    input  logic       ins,
    input  logic       clear,
    output sort_slot_t slot,
    output logic       gt
);

    // Strict compare: on equal power the resident (earlier) beam keeps its rank.
    assign gt = !slot.vld || (new_slot.pwr > slot.pwr);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot <= '0;
        end else if (clear) begin
            // A flush empties the list; only the top slot may take a sample arriving alongside it.
            slot <= (IS_TOP && ins) ? new_slot : '0;
        end else if (ins && gt) begin
            slot <= upper_gt ? upper_slot : new_slot;
        end
    end

endmodule

// File: rtl/beam_power_sort.sv
// Streaming top-BEAM beam selector: sorts one RBG of beam powers by parallel insertion
// and presents the strongest beam indices with a one-cycle load strobe.
module beam_power_sort
    import pusch_dr_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_pwr_valid,
    input  logic [PWR_W-1:0]            i_pwr,
    input  logic                        i_pwr_sop,
    input  logic                        i_pwr_eop,
    output logic [BEAM-1:0][IDX_W-1:0]  o_beam_idx,
    output logic                        o_rbg_load,
    output logic                        o_err,
    output logic                        o_busy
);

    // Input side is valid-only: a sample is consumed on every cycle i_pwr_valid is high,
    // sop/eop are meaningful only with valid, and there is no backpressure.
    logic             accept;
    logic             sat;
    logic             ignored;
    logic             ins;
    logic             flush;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic             eop_d1;
    logic             err_d1;
    sort_slot_t       new_slot;
    sort_slot_t       slots [BEAM];
    logic [BEAM-1:0]  gt;

    assign accept  = i_pwr_valid;
    assign sat     = (cnt == CNT_W'(NBEAMS));
    assign ignored = accept && !i_pwr_sop && sat;
    assign ins     = accept && !ignored;
    // The list empties on a new sop and in the cycle after eop (list is being unloaded).
    assign flush   = (accept && i_pwr_sop) || eop_d1;

    assign new_slot.vld = 1'b1;
    assign new_slot.pwr = i_pwr;
    assign new_slot.idx = i_pwr_sop ? '0 : IDX_W'(cnt);

    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (accept && i_pwr_sop) begin
            cnt_nxt = CNT_W'(1);
            ovf_nxt = 1'b0;
        end else if (accept) begin
            if (!sat) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            ovf_nxt = ovf || ignored;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt    <= '0;
            ovf    <= 1'b0;
            eop_d1 <= 1'b0;
            err_d1 <= 1'b0;
        end else if (accept && i_pwr_eop) begin
            // Count restarts so an RBG that arrives without sop still indexes from 0.
            cnt    <= '0;
            ovf    <= 1'b0;
            eop_d1 <= 1'b1;
            err_d1 <= (cnt_nxt != CNT_W'(NBEAMS)) || ovf_nxt;
        end else begin
            cnt    <= cnt_nxt;
            ovf    <= ovf_nxt;
            eop_d1 <= 1'b0;
        end
    end

    for (genvar k = 0; k < BEAM; k++) begin : g_cell
        if (k == 0) begin : g_top
            beam_sort_cell #(.IS_TOP(1'b1)) u_cell (
                .i_clk      (i_clk),
                .i_reset_n  (i_reset_n),
                .upper_slot (new_slot),
                .new_slot   (new_slot),
                .upper_gt   (1'b0),
                .ins        (ins),
                .clear      (flush),
                .slot       (slots[k]),
                .gt         (gt[k])
            );
        end else begin : g_rest
            beam_sort_cell #(.IS_TOP(1'b0)) u_cell (
                .i_clk      (i_clk),
                .i_reset_n  (i_reset_n),
                .upper_slot (slots[k-1]),
                .new_slot   (new_slot),
                .upper_gt   (gt[k-1]),
                .ins        (ins),
                .clear      (flush),
                .slot       (slots[k]),
                .gt         (gt[k])
            );
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_beam_idx <= '0;
            o_rbg_load <= 1'b0;
            o_err      <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_rbg_load <= eop_d1;
            o_err      <= eop_d1 && err_d1;
            if (eop_d1) begin
                for (int k = 0; k < BEAM; k++) begin
                    o_beam_idx[k] <= slots[k].vld ? slots[k].idx : '0;
                end
            end
            if (accept && i_pwr_sop) begin
                o_busy <= 1'b1;
            end else if (eop_d1) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beam_power_sort.sv
// Directed bench for beam_power_sort: drives RBGs of beam powers and checks each
// load against a reference top-BEAM selection, its error flag and its latency.
module tb_beam_power_sort;
    import pusch_dr_pkg::*;

    logic                        i_clk;
    logic                        i_reset_n;
    logic                        i_pwr_valid;
    logic [PWR_W-1:0]            i_pwr;
    logic                        i_pwr_sop;
    logic                        i_pwr_eop;
    logic [BEAM-1:0][IDX_W-1:0]  o_beam_idx;
    logic                        o_rbg_load;
    logic                        o_err;
    logic                        o_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [IDX_W-1:0] exp_q [$];
    logic             err_q [$];
    int               lat_q [$];

    logic [PWR_W-1:0] m_pwr [0:NBEAMS-1];
    int               m_cnt = 0;
    bit               m_ovf = 0;

    beam_power_sort dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_pwr_valid (i_pwr_valid),
        .i_pwr       (i_pwr),
        .i_pwr_sop   (i_pwr_sop),
        .i_pwr_eop   (i_pwr_eop),
        .o_beam_idx  (o_beam_idx),
        .o_rbg_load  (o_rbg_load),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference: stable top-BEAM selection over the accepted samples
    task automatic model_eop(input int lat);
        bit used [0:NBEAMS-1];
        int n;
        n = (m_cnt > NBEAMS) ? NBEAMS : m_cnt;
        for (int i = 0; i < NBEAMS; i++) used[i] = 1'b0;
        for (int k = 0; k < BEAM; k++) begin
            int best;
            best = -1;
            for (int i = 0; i < n; i++) begin
                if (!used[i] && (best < 0 || m_pwr[i] > m_pwr[best])) best = i;
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_q.push_back(IDX_W'(best));
            end else begin
                exp_q.push_back('0);
            end
        end
        err_q.push_back((m_cnt != NBEAMS) || m_ovf);
        lat_q.push_back(lat);
        m_cnt = 0;
        m_ovf = 0;
    endtask

    // driver
    task automatic send(input logic [PWR_W-1:0] p, input logic sop, input logic eop, input int gap);
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        i_pwr_valid = 1'b1;
        i_pwr       = p;
        i_pwr_sop   = sop;
        i_pwr_eop   = eop;
        if (sop) begin
            m_cnt = 0;
            m_ovf = 0;
        end
        if (m_cnt < NBEAMS) begin
            m_pwr[m_cnt] = p;
            m_cnt++;
        end else begin
            m_ovf = 1;
        end
        if (eop) model_eop(cyc + 2);
        @(posedge i_clk);
        #1;
        i_pwr_valid = 1'b0;
        i_pwr_sop   = 1'b0;
        i_pwr_eop   = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (lat_q.size() != 0 && b < 20) begin
            @(negedge i_clk);
            b++;
        end
        if (lat_q.size() != 0) begin
            check("load_timeout", lat_q.size(), 0);
            exp_q.delete();
            err_q.delete();
            lat_q.delete();
        end
        repeat (2) @(negedge i_clk);
    endtask

    // scoreboard
    always @(negedge i_clk) begin
        if (i_reset_n && o_rbg_load) begin
            if (lat_q.size() == 0) begin
                check("unexp_load", o_rbg_load, 0);
            end else begin
                for (int k = 0; k < BEAM; k++) begin
                    check($sformatf("idx%0d", k), o_beam_idx[k], exp_q.pop_front());
                end
                check("err", o_err, err_q.pop_front());
                check("lat", cyc, lat_q.pop_front());
            end
        end
    end

    initial begin
        int gap;
        i_reset_n   = 1'b0;
        i_pwr_valid = 1'b0;
        i_pwr       = '0;
        i_pwr_sop   = 1'b0;
        i_pwr_eop   = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_idx",  {31'b0, |o_beam_idx}, 0);
        check("rst_load", o_rbg_load, 0);
        check("rst_err",  o_err, 0);
        check("rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // T1 ramp
        for (int i = 0; i < NBEAMS; i++) begin
            send(i, i == 0, i == NBEAMS - 1, 0);
            if (i == 5) check("busy_mid", o_busy, 1);
        end
        drain();
        check("busy_after", o_busy, 0);

        // T2 ties
        for (int i = 0; i < NBEAMS; i++) send(100, i == 0, i == NBEAMS - 1, 0);
        drain();

        // T3 descending with idle gaps
        for (int i = 0; i < NBEAMS; i++) begin
            gap = $urandom_range(0, 3);
            send(1000 - i, i == 0, i == NBEAMS - 1, gap);
        end
        drain();

        // T4 short RBG of 10 samples
        begin
            int short_p [10] = '{5, 9, 2, 9, 40, 1, 0, 17, 3, 22};
            for (int i = 0; i < 10; i++) send(short_p[i], i == 0, i == 9, 0);
        end
        drain();
        // T4 long RBG of 70 samples; the strongest ones arrive after the overflow point
        for (int i = 0; i < 70; i++) begin
            send((i >= NBEAMS) ? 32'hFFFF_0000 + i : $urandom_range(0, 5000), i == 0, i == 69, 0);
        end
        drain();
        // single-entry RBG
        send(77, 1'b1, 1'b1, 0);
        drain();

        // T5 restart at sample 30, then back-to-back full RBGs
        for (int i = 0; i < 30; i++) send(9000 + i, i == 0, 1'b0, 0);
        for (int i = 0; i < NBEAMS; i++) send($urandom_range(0, 300), i == 0, i == NBEAMS - 1, 0);
        for (int i = 0; i < NBEAMS; i++) send((i * 37) % 101, i == 0, i == NBEAMS - 1, 0);
        drain();

        // T6 reset mid-RBG
        for (int i = 0; i < 20; i++) send(i + 1, i == 0, 1'b0, 0);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        check("rst6_idx",  {31'b0, |o_beam_idx}, 0);
        check("rst6_load", o_rbg_load, 0);
        check("rst6_busy", o_busy, 0);
        m_cnt = 0;
        m_ovf = 0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (4) @(negedge i_clk);
        for (int i = 0; i < NBEAMS; i++) send((i * 53) % 64, i == 0, i == NBEAMS - 1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
